sig_table_loader: RTL and testbench

Runtime writer for the sigmoid activation lookup table of the ELM hidden layer. It accepts a full table of sigmoid entries over a valid/ready stream and writes them sequentially into an internal single-clock RAM of 2**inWidth entries. It then serves activation lookups from that RAM using the offset-binary addressing and saturation rule of the hidden-layer sigmoid. It replaces the synthesis-time table image, so the activation curve can be reloaded without rebuilding.

---
 rtl/sig_table_loader.sv | 150 +++++++++++++++
 tb/tb_sig_table_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_table_loader.sv
// Runtime-loadable sigmoid lookup table for the ELM hidden layer: a valid/ready stream fills
// a single-clock RAM, which then serves 1-cycle offset-binary lookups with negative saturation.
module sig_table_loader #(
   parameter int unsigned              inWidth    = 10,
   parameter int unsigned              entryWidth = 12,
   parameter logic [entryWidth-1:0]    SAT_VALUE  = 12'h100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [entryWidth-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  busy,
   output logic                  table_valid,
   output logic                  err,
   output logic [inWidth:0]      wr_count,
   input  logic                  lk_valid,
   input  logic [inWidth-1:0]    lk_x,
   input  logic                  lk_sign_flag,
   output logic [entryWidth-1:0] lk_out,
   output logic                  lk_out_valid
);

   localparam int unsigned Depth = 2 ** inWidth;

   typedef enum logic [1:0] {StIdle, StLoad, StReady, StError} state_e;

   state_e                state_q, state_d;
   logic [inWidth:0]      wr_count_q, wr_count_d;
   logic                  table_valid_q, table_valid_d;
   logic                  err_q, err_d;
   logic                  wr_en;
   logic [inWidth-1:0]    wr_addr;
   logic                  last_beat;

   logic [entryWidth-1:0] mem_q [Depth];
   logic [entryWidth-1:0] rd_data_q;
   logic                  sat_q;
   logic                  lk_out_valid_q;
   logic                  rd_en;
   logic [inWidth-1:0]    lk_addr;

   assign wr_addr   = wr_count_q[inWidth-1:0];
   assign last_beat = (wr_addr == {inWidth{1'b1}});

   // ------------------------------------------------------------------
   // Load control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      wr_count_d    = wr_count_q;
      table_valid_d = table_valid_q;
      err_d         = err_q;
      wr_en         = 1'b0;

      unique case (state_q)
         StIdle, StReady, StError: begin
            if (start) begin
               state_d       = StLoad;
               wr_count_d    = '0;
               table_valid_d = 1'b0;
               err_d         = 1'b0;
            end
         end
         StLoad: begin
            // A restart takes priority over a beat presented in the same cycle.
            if (start) begin
               wr_count_d = '0;
            end else if (s_valid) begin
               wr_en      = 1'b1;
               wr_count_d = wr_count_q + 1'b1;
               if (last_beat) begin
                  if (s_last) begin
                     state_d       = StReady;
                     table_valid_d = 1'b1;
                  end else begin
                     state_d = StError;
                     err_d   = 1'b1;
                  end
               end else if (s_last) begin
                  state_d = StError;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         wr_count_q    <= '0;
         table_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_count_q    <= wr_count_d;
         table_valid_q <= table_valid_d;
         err_q         <= err_d;
      end
   end

   assign s_ready     = (state_q == StLoad);
   assign busy        = (state_q == StLoad);
   assign table_valid = table_valid_q;
   assign err         = err_q;
   assign wr_count    = wr_count_q;

   // ------------------------------------------------------------------
   // Table RAM and lookup pipeline
   // ------------------------------------------------------------------
   // Flipping the sign bit maps signed x onto beat order (beat 0 = most negative x).
   assign lk_addr = {~lk_x[inWidth-1], lk_x[inWidth-2:0]};
   assign rd_en   = lk_valid & table_valid_q;

   // RAM contents survive reset; table_valid alone qualifies their use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= s_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[lk_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q          <= 1'b0;
         lk_out_valid_q <= 1'b0;
      end else begin
         lk_out_valid_q <= rd_en;
         if (rd_en) begin
            sat_q <= ~lk_sign_flag & lk_x[inWidth-1];
         end
      end
   end

   always_comb begin
      lk_out = '0;
      if (lk_out_valid_q) begin
         lk_out = sat_q ? SAT_VALUE : rd_data_q;
      end
   end

   assign lk_out_valid = lk_out_valid_q;

endmodule

// File: tb/tb_sig_table_loader.sv
// Scoreboard bench for sig_table_loader: lookups push expected results into a queue that a
// negedge monitor drains whenever lk_out_valid is seen.
module tb_sig_table_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [11:0] s_data;
   logic        s_last;
   logic        s_ready;
   logic        busy;
   logic        table_valid;
   logic        err;
   logic [10:0] wr_count;
   logic        lk_valid;
   logic [9:0]  lk_x;
   logic        lk_sign_flag;
   logic [11:0] lk_out;
   logic        lk_out_valid;

   int          nerr    = 0;
   int          nchecks = 0;
   bit          mon_en  = 1'b0;
   logic [11:0] model [1024];
   logic [11:0] exp_q [$];

   sig_table_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .busy         (busy),
      .table_valid  (table_valid),
      .err          (err),
      .wr_count     (wr_count),
      .lk_valid     (lk_valid),
      .lk_x         (lk_x),
      .lk_sign_flag (lk_sign_flag),
      .lk_out       (lk_out),
      .lk_out_valid (lk_out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per valid result; idle output must read zero.
   always @(negedge clk) begin
      if (mon_en) begin
         if (lk_out_valid === 1'b1) begin
            nchecks++;
            if (exp_q.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_lookup: got lk_out=0x%0h expected no result", lk_out);
            end else begin
               automatic logic [11:0] e = exp_q.pop_front();
               if (lk_out !== e) begin
                  nerr++;
                  $display("FAIL lookup_data: got 0x%0h expected 0x%0h", lk_out, e);
               end
            end
         end else begin
            nchecks++;
            if (lk_out !== 12'h000 || lk_out_valid !== 1'b0) begin
               nerr++;
               $display("FAIL idle_out: got lk_out=0x%0h valid=%b expected 0x0 valid=0",
                        lk_out, lk_out_valid);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [11:0] beat_data(input int mode, input int k);
      case (mode)
         0:       return 12'(k);
         1:       return 12'(1023 - k);
         default: return 12'((k * 7 + 3) & 12'hFFF);
      endcase
   endfunction

   // Streams nbeats handshaked beats; s_last on beat last_at (-1 = never).
   task automatic load_table(input int nbeats, input int last_at, input int mode, input bit gaps);
      int k = 0;
      int guard = 0;
      while (k < nbeats && guard < 5000) begin
         s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_data  = beat_data(mode, k);
         s_last  = (k == last_at);
         if (s_valid && s_ready) begin
            model[k] = s_data;
            k++;
         end
         tick();
         guard++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (k < nbeats) begin
         chk("load_timeout_beats", k, nbeats);
      end
   endtask

   task automatic lookup(input logic [9:0] x, input logic sf, input bit expect_out,
                         input logic [11:0] e);
      lk_valid     = 1'b1;
      lk_x         = x;
      lk_sign_flag = sf;
      if (expect_out) exp_q.push_back(e);
      tick();
      lk_valid = 1'b0;
   endtask

   function automatic logic [11:0] model_lookup(input logic [9:0] x, input logic sf);
      logic [9:0] a;
      if (!sf && x[9]) return 12'h100;
      a = {~x[9], x[8:0]};
      return model[a];
   endfunction

   task automatic drain(input string name);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         tick();
         guard++;
      end
      tick();
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      s_last       = 1'b0;
      lk_valid     = 1'b0;
      lk_x         = '0;
      lk_sign_flag = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      tick();
      mon_en = 1'b1;

      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_table_valid", table_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_count", wr_count, 0);
      lookup(10'd0, 1'b1, 1'b0, 12'h0);
      tick();

      // Full ascending load.
      do_start();
      chk("load_s_ready", s_ready, 1);
      chk("load_busy", busy, 1);
      chk("load_wr_count0", wr_count, 0);
      load_table(1024, 1023, 0, 1'b0);
      chk("full_table_valid", table_valid, 1);
      chk("full_wr_count", wr_count, 1024);
      chk("full_err", err, 0);
      chk("full_s_ready", s_ready, 0);

      lookup(10'd0, 1'b1, 1'b1, 12'h200);
      lookup(10'h200, 1'b1, 1'b1, 12'h000);   // x = -512
      lookup(10'h1FF, 1'b1, 1'b1, 12'h3FF);   // x = 511
      lookup(10'h3FF, 1'b0, 1'b1, 12'h100);   // x = -1, saturates
      lookup(10'h3FF, 1'b1, 1'b1, 12'h1FF);
      lookup(10'h200, 1'b0, 1'b1, 12'h100);
      lookup(10'h1FF, 1'b0, 1'b1, 12'h3FF);   // positive x never saturates
      drain("drain_full");

      // Early s_last -> framing error.
      do_start();
      load_table(6, 5, 0, 1'b0);
      chk("early_err", err, 1);
      chk("early_table_valid", table_valid, 0);
      chk("early_s_ready", s_ready, 0);
      chk("early_wr_count", wr_count, 6);
      lookup(10'd0, 1'b1, 1'b0, 12'h0);
      lookup(10'd5, 1'b1, 1'b0, 12'h0);
      chk("early_no_lookup", lk_out_valid, 0);
      drain("drain_err");

      // Restart mid-load; start beats a same-cycle handshake.
      do_start();
      chk("restart_err_cleared", err, 0);
      load_table(3, -1, 2, 1'b0);
      chk("restart_pre_count", wr_count, 3);
      start   = 1'b1;
      s_valid = 1'b1;
      s_data  = 12'hABC;
      tick();
      start   = 1'b0;
      s_valid = 1'b0;
      chk("restart_wr_count", wr_count, 0);
      chk("restart_busy", busy, 1);

      // Full scrambled load with random gaps, then back-to-back lookups.
      load_table(1024, 1023, 2, 1'b1);
      chk("gap_table_valid", table_valid, 1);
      chk("gap_wr_count", wr_count, 1024);
      for (int i = 0; i < 48; i++) begin
         automatic logic [9:0] x = 10'($urandom_range(0, 1023));
         automatic logic sf = 1'($urandom_range(0, 1));
         lookup(x, sf, 1'b1, model_lookup(x, sf));
         lk_valid = 1'b1;
      end
      lk_valid = 1'b0;
      drain("drain_random");

      // Reset at beat 300, then full descending reload.
      do_start();
      load_table(300, -1, 1, 1'b0);
      chk("mid_wr_count", wr_count, 300);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_table_valid", table_valid, 0);
      chk("mid_rst_wr_count", wr_count, 0);
      lookup(10'd0, 1'b1, 1'b0, 12'h0);
      tick();
      do_start();
      load_table(1024, 1023, 1, 1'b0);
      chk("reload_table_valid", table_valid, 1);
      lookup(10'd0, 1'b1, 1'b1, 12'h1FF);
      lookup(10'h200, 1'b1, 1'b1, 12'h3FF);   // x = -512 -> entry 0
      lookup(10'h2D4, 1'b1, 1'b1, 12'h32B);   // x = -300 -> entry 212
      lookup(10'h1FF, 1'b1, 1'b1, 12'h000);
      drain("drain_reload");

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
